bp_fe_queue_replay_fifo: RTL and testbench
==========================================

# bp_fe_queue_replay_fifo

Parametrised replay FIFO between the front end and the back end, replacing the fixed single-step rolly FIFO on the FE queue path. It holds fetched instructions until the back end commits them, supports replay from the oldest uncommitted entry and full flush on redirect, and adds a multi-entry commit per cycle plus an occupancy output for FE throttling. It sits in the core between the FE fe_queue output and the BE issue stage.

## Interface
- width_p, none: entry width (fe_queue_width_lp at instantiation).
- els_p, 8: depth; power of two, >= 2.
- deq_width_p, 1: maximum entries committed per cycle; 1..els_p.
- ready_THEN_valid_p, 1: 1 means producer asserts v_i only when ready_o is high; 0 means enqueue = v_i & ready_o.
- clk_i  in  1  clock.
- reset_i  in  1  reset; asynchronous, active-high.
- data_i  in  width_p  enqueue data.
- v_i  in  1  enqueue valid.
- ready_o  out  1  space available.
- data_o  out  width_p  entry at read pointer.
- v_o  out  1  unread entry available.
- yumi_i  in  1  consumer takes data_o; legal only when v_o.
- deq_v_i  in  1  commit request.
- deq_cnt_i  in  clog2(deq_width_p+1)  entries to commit; 1..deq_width_p when deq_v_i.
- roll_v_i  in  1  replay: read pointer returns to commit pointer.
- clr_v_i  in  1  flush all uncommitted entries.
- count_o  out  clog2(els_p+1)  uncommitted occupancy (wptr - cptr).

## Operation
- Three wrap pointers, width clog2(els_p)+1 (extra wrap bit): cptr (oldest uncommitted), rptr (next to read), wptr (next to write). Invariant cptr <= rptr <= wptr, wptr - cptr <= els_p, all modulo 2^ptr width.
- ready_o = (wptr - cptr) != els_p; v_o = rptr != wptr; data_o = mem[rptr low bits].
- Enqueue: mem[wptr] <= data_i, wptr += 1.
- yumi_i: rptr += 1. Entry remains stored until committed.
- deq_v_i: cptr += deq_cnt_i. deq_cnt_i > rptr - cptr (committing unread entries) is illegal; assertion fires in simulation.
- roll_v_i: rptr <= new cptr (after this cycle's commit). yumi_i that cycle ignored.
- clr_v_i: rptr <= new cptr, wptr <= new cptr. Enqueue and yumi_i that cycle dropped (FE is being redirected in same cycle). clr dominates roll.
- Evaluation order per cycle: commit, then clr/roll, else enqueue/yumi.
- Full and commit same cycle: ready_o reflects current state only (no pass-through of freed space).

## Timing
- Reset (async): cptr = rptr = wptr = 0; ready_o = 1, v_o = 0, count_o = 0; data_o undefined (mem not reset).
- Read is combinational from storage: zero-cycle read latency.
- Enqueued entry visible on v_o the cycle after enqueue (see Configuration).
- Pointer updates, count_o, ready_o change one cycle after the causing event.
- Wrap: pointers wrap at 2^(clog2(els_p)+1); full/empty distinguished by wrap bit.
- Reset asserted mid-operation: all pointers clear immediately; stored data abandoned.

## Configuration
- BP_FE_QUEUE_BYPASS_EN defined: when rptr == wptr and enqueue occurs without clr, data_o = data_i and v_o = 1 same cycle; yumi_i that cycle advances rptr and entry is still written for replay. count_o unchanged by bypass.
- Undefined: no bypass; one-cycle enqueue-to-v_o latency.

## Structure
- Pointer-width and count-width localparam helpers belong in bp_common_pkg (shared with fe_cmd FIFO sizing).
- One sub-module: bp_queue_wrap_ptr, wrap-bit pointer with variable increment (0..deq_width_p) and synchronous load; instantiated three times (wptr/rptr increment 1, cptr increment deq_cnt_i).
- Storage: 1r1w register file, asynchronous read, els_p x width_p.

## Test plan
- Fill: els_p=8, 8 enqueues, no yumi -> ready_o=0, count_o=8, v_o=1; 9th v_i not accepted (ready_THEN_valid_p=0).
- Replay: enqueue A..D, yumi x3, roll_v_i -> next cycle data_o=A, count_o=4; yumi x4 returns A,B,C,D.
- Multi-commit: deq_width_p=2, enqueue 4, yumi x4, deq_cnt_i=2 twice -> count_o 4->2->0, ready_o=1.
- Flush with commit: 5 entries, 3 read, deq_cnt_i=1 with clr_v_i and v_i same cycle -> count_o=0, v_o=0, new entry dropped.
- Wrap: 20 enqueue/yumi/commit cycles on els_p=8 -> data order preserved across wrap, no spurious full/empty.
- Bypass (macro on): empty FIFO, v_i=1 data 0x5A with yumi_i=1 -> same-cycle data_o=0x5A, v_o=1; roll next cycle -> data_o=0x5A again.

Source files
------------

// File: rtl/bp_common_pkg.sv
// bp_common_pkg
//   Sizing helpers shared by the front-end queues (FE queue replay FIFO and
//   the fe_cmd FIFO).
//   ptr_width(els) : width of a wrap-bit pointer for an els-deep queue
//                    (index bits plus one wrap bit).
//   cnt_width(n)   : width needed to hold a count in the range 0..n.
package bp_common_pkg;

   function automatic int ptr_width(input int els);
      return $clog2(els) + 1;
   endfunction

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/bp_queue_wrap_ptr.sv
// bp_queue_wrap_ptr
//   Wrap-bit queue pointer. Its MSB is the wrap bit, so that two pointers with
//   equal index bits can still be told apart as "full" or "empty". The
//   increment is variable, and a synchronous load overrides the increment.
//   Ports:
//     clk_i, reset_i : clock; asynchronous active-high reset (pointer -> 0)
//     inc_i          : amount to advance this cycle (0 holds)
//     load_v_i       : load load_val_i instead of incrementing
//     load_val_i     : value to load
//     ptr_o          : current pointer value
module bp_queue_wrap_ptr #(
   parameter int width_p = 4
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [width_p-1:0] inc_i,
   input  logic               load_v_i,
   input  logic [width_p-1:0] load_val_i,
   output logic [width_p-1:0] ptr_o
);

   logic [width_p-1:0] ptr_n;

   // The natural modulo-2^width_p overflow of the adder performs the wrap.
   assign ptr_n = load_v_i ? load_val_i : ptr_o + inc_i;

   // NOTE: state is updated with non-blocking assignments only, so every
   // flop samples the values from before the clock edge.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) ptr_o <= '0;
      else         ptr_o <= ptr_n;
   end

endmodule

// File: rtl/bp_fe_queue_replay_fifo.sv
// bp_fe_queue_replay_fifo
//   Replay FIFO between the FE queue output and the BE issue stage. Entries
//   stay stored after they are read, until the back end commits them. This
//   allows a replay from the oldest uncommitted entry (roll) and a full flush
//   on redirect (clr). Up to deq_width_p entries can be committed per cycle.
//   Optional macro BP_FE_QUEUE_BYPASS_EN: when the FIFO has no unread entry,
//   an enqueue appears on data_o/v_o in the same cycle, and the entry is
//   still written so that it can be replayed.
//   Ports:
//     clk_i, reset_i   : clock; asynchronous active-high reset
//     data_i, v_i      : enqueue data and valid; ready_o means space is free
//     data_o, v_o      : entry at the read pointer; yumi_i consumes it
//     deq_v_i          : commit request
//     deq_cnt_i        : number of entries to commit (1..deq_width_p)
//     roll_v_i         : replay; the read pointer returns to the commit pointer
//     clr_v_i          : flush every uncommitted entry
//     count_o          : uncommitted occupancy (wptr - cptr)
module bp_fe_queue_replay_fifo
   import bp_common_pkg::*;
#(
   parameter int width_p            = 8,
   parameter int els_p              = 8,
   parameter int deq_width_p        = 1,
   parameter int ready_THEN_valid_p = 1,
   localparam int ptr_w_lp          = ptr_width(els_p),
   localparam int cnt_w_lp          = cnt_width(els_p),
   localparam int deq_cnt_w_lp      = cnt_width(deq_width_p)
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [width_p-1:0]      data_i,
   input  logic                    v_i,
   output logic                    ready_o,
   output logic [width_p-1:0]      data_o,
   output logic                    v_o,
   input  logic                    yumi_i,
   input  logic                    deq_v_i,
   input  logic [deq_cnt_w_lp-1:0] deq_cnt_i,
   input  logic                    roll_v_i,
   input  logic                    clr_v_i,
   output logic [cnt_w_lp-1:0]     count_o
);

   logic [ptr_w_lp-1:0] cptr, rptr, wptr;
   logic [ptr_w_lp-1:0] commit_inc, cptr_n, occupancy;
   logic                accept, enq, yumi_eff, stored_v;
   logic [width_p-1:0]  mem [els_p];

   // The commit is applied first. Roll and clr then target the commit
   // pointer after this cycle's commit.
   assign commit_inc = deq_v_i ? ptr_w_lp'(deq_cnt_i) : '0;
   assign cptr_n     = cptr + commit_inc;

   assign occupancy = wptr - cptr;
   assign count_o   = cnt_w_lp'(occupancy);
   // Full is judged on the current state only. Space freed by a commit in
   // the same cycle is not passed through.
   assign ready_o   = occupancy != ptr_w_lp'(els_p);

   assign accept = (ready_THEN_valid_p != 0) ? v_i : (v_i & ready_o);
   // The FE is being redirected in the same cycle as a flush, so the enqueue
   // is dropped.
   assign enq    = accept & ~clr_v_i;

   assign stored_v = rptr != wptr;

`ifdef BP_FE_QUEUE_BYPASS_EN
   logic bypass;
   assign bypass = enq & (rptr == wptr);
   assign v_o    = stored_v | bypass;
   assign data_o = bypass ? data_i : mem[rptr[ptr_w_lp-2:0]];
`else
   assign v_o    = stored_v;
   assign data_o = mem[rptr[ptr_w_lp-2:0]];
`endif

   // A roll or clr repositions rptr, so a read in the same cycle is ignored.
   assign yumi_eff = yumi_i & v_o & ~roll_v_i & ~clr_v_i;

   bp_queue_wrap_ptr #(.width_p(ptr_w_lp)) cptr_reg (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .inc_i      (commit_inc),
      .load_v_i   (1'b0),
      .load_val_i ('0),
      .ptr_o      (cptr)
   );

   bp_queue_wrap_ptr #(.width_p(ptr_w_lp)) rptr_reg (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .inc_i      (ptr_w_lp'(yumi_eff)),
      .load_v_i   (roll_v_i | clr_v_i),
      .load_val_i (cptr_n),
      .ptr_o      (rptr)
   );

   bp_queue_wrap_ptr #(.width_p(ptr_w_lp)) wptr_reg (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .inc_i      (ptr_w_lp'(enq)),
      .load_v_i   (clr_v_i),
      .load_val_i (cptr_n),
      .ptr_o      (wptr)
   );

   // NOTE: the storage array has no reset. The pointers alone decide which
   // entries are valid, and leaving the array unreset keeps it a plain
   // register file.
   always_ff @(posedge clk_i) begin
      if (enq) mem[wptr[ptr_w_lp-2:0]] <= data_i;
   end

   // A commit may only retire entries that have already been read.
   deq_legal_a: assert property (@(posedge clk_i) disable iff (reset_i)
      deq_v_i |-> (deq_cnt_i != '0) && (ptr_w_lp'(deq_cnt_i) <= (rptr - cptr)));

   yumi_legal_a: assert property (@(posedge clk_i) disable iff (reset_i)
      yumi_i |-> v_o);

endmodule

// File: tb/tb_bp_fe_queue_replay_fifo.sv
// tb_bp_fe_queue_replay_fifo
//   Directed bench for bp_fe_queue_replay_fifo with els_p=8, deq_width_p=2,
//   ready_THEN_valid_p=0 and width_p=8. Inputs are driven 1 time unit after
//   the rising edge, and outputs are sampled before the next rising edge.
module tb_bp_fe_queue_replay_fifo;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic [7:0] data_i;
   logic       v_i, ready_o, v_o, yumi_i, deq_v_i, roll_v_i, clr_v_i;
   logic [7:0] data_o;
   logic [1:0] deq_cnt_i;
   logic [3:0] count_o;

   int pass_cnt  = 0;
   int total_cnt = 0;

   bp_fe_queue_replay_fifo #(
      .width_p(8), .els_p(8), .deq_width_p(2), .ready_THEN_valid_p(0)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .v_i(v_i),
      .ready_o(ready_o), .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i),
      .deq_v_i(deq_v_i), .deq_cnt_i(deq_cnt_i), .roll_v_i(roll_v_i),
      .clr_v_i(clr_v_i), .count_o(count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      v_i = 1'b0; data_i = 8'h00; yumi_i = 1'b0; deq_v_i = 1'b0;
      deq_cnt_i = 2'd0; roll_v_i = 1'b0; clr_v_i = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);
      v_i = 1'b1; data_i = d; tick(); idle();
   endtask

   task automatic pop();
      yumi_i = 1'b1; tick(); idle();
   endtask

   task automatic commit(input logic [1:0] n);
      deq_v_i = 1'b1; deq_cnt_i = n; tick(); idle();
   endtask

   task automatic do_reset();
      idle();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      reset_i = 1'b1;
      #12;
      total_cnt++; if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready_o); else pass_cnt++;
      total_cnt++; if (v_o !== 1'b0) $display("FAIL reset_v: got %b expected 0", v_o); else pass_cnt++;
      total_cnt++; if (count_o !== 4'd0) $display("FAIL reset_count: got %0d expected 0", count_o); else pass_cnt++;
      tick();
      reset_i = 1'b0;
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
      total_cnt++; if (ready_o !== 1'b0) $display("FAIL fill_ready: got %b expected 0", ready_o); else pass_cnt++;
      total_cnt++; if (count_o !== 4'd8) $display("FAIL fill_count: got %0d expected 8", count_o); else pass_cnt++;
      total_cnt++; if (v_o !== 1'b1) $display("FAIL fill_v: got %b expected 1", v_o); else pass_cnt++;
      total_cnt++; if (data_o !== 8'h10) $display("FAIL fill_head: got %h expected 10", data_o); else pass_cnt++;
      push(8'h99);
      total_cnt++; if (count_o !== 4'd8) $display("FAIL fill_ninth_dropped: got %0d expected 8", count_o); else pass_cnt++;
      // Reset in the middle of operation clears the pointers without a clock edge.
      reset_i = 1'b1;
      #1;
      total_cnt++; if (count_o !== 4'd0) $display("FAIL midreset_count: got %0d expected 0", count_o); else pass_cnt++;
      total_cnt++; if (v_o !== 1'b0) $display("FAIL midreset_v: got %b expected 0", v_o); else pass_cnt++;
      total_cnt++; if (ready_o !== 1'b1) $display("FAIL midreset_ready: got %b expected 1", ready_o); else pass_cnt++;
      tick();
      reset_i = 1'b0;
   endtask

   task automatic test_replay();
      do_reset();
      for (int i = 0; i < 4; i++) push(8'(8'hA0 + i));
      for (int i = 0; i < 3; i++) begin
         total_cnt++; if (data_o !== 8'(8'hA0 + i)) $display("FAIL replay_first_read%0d: got %h expected %h", i, data_o, 8'(8'hA0 + i)); else pass_cnt++;
         pop();
      end
      roll_v_i = 1'b1; tick(); idle();
      total_cnt++; if (data_o !== 8'hA0) $display("FAIL replay_head: got %h expected a0", data_o); else pass_cnt++;
      total_cnt++; if (count_o !== 4'd4) $display("FAIL replay_count: got %0d expected 4", count_o); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         total_cnt++; if (v_o !== 1'b1 || data_o !== 8'(8'hA0 + i)) $display("FAIL replay_reread%0d: got v=%b %h expected v=1 %h", i, v_o, data_o, 8'(8'hA0 + i)); else pass_cnt++;
         pop();
      end
      total_cnt++; if (v_o !== 1'b0) $display("FAIL replay_drained_v: got %b expected 0", v_o); else pass_cnt++;
   endtask

   task automatic test_multi_commit();
      do_reset();
      for (int i = 0; i < 4; i++) push(8'(8'hB0 + i));
      for (int i = 0; i < 4; i++) pop();
      total_cnt++; if (count_o !== 4'd4) $display("FAIL mc_count_before: got %0d expected 4", count_o); else pass_cnt++;
      commit(2'd2);
      total_cnt++; if (count_o !== 4'd2) $display("FAIL mc_count_after1: got %0d expected 2", count_o); else pass_cnt++;
      commit(2'd2);
      total_cnt++; if (count_o !== 4'd0) $display("FAIL mc_count_after2: got %0d expected 0", count_o); else pass_cnt++;
      total_cnt++; if (ready_o !== 1'b1) $display("FAIL mc_ready: got %b expected 1", ready_o); else pass_cnt++;
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
      for (int i = 0; i < 3; i++) pop();
      deq_v_i = 1'b1; deq_cnt_i = 2'd1; clr_v_i = 1'b1; v_i = 1'b1; data_i = 8'hEE;
      tick(); idle();
      total_cnt++; if (count_o !== 4'd0) $display("FAIL flush_count: got %0d expected 0", count_o); else pass_cnt++;
      total_cnt++; if (v_o !== 1'b0) $display("FAIL flush_v: got %b expected 0", v_o); else pass_cnt++;
      total_cnt++; if (ready_o !== 1'b1) $display("FAIL flush_ready: got %b expected 1", ready_o); else pass_cnt++;
      push(8'h77);
      total_cnt++; if (count_o !== 4'd1 || data_o !== 8'h77) $display("FAIL flush_after_enq: got count=%0d data=%h expected count=1 data=77", count_o, data_o); else pass_cnt++;
   endtask

   task automatic test_wrap();
      do_reset();
      // Iteration k: k entries written, k-1 read, max(k-2,0) committed.
      for (int k = 0; k < 20; k++) begin
         total_cnt++; if (count_o !== 4'((k < 2) ? k : 2)) $display("FAIL wrap_count%0d: got %0d expected %0d", k, count_o, (k < 2) ? k : 2); else pass_cnt++;
         total_cnt++; if (ready_o !== 1'b1) $display("FAIL wrap_ready%0d: got %b expected 1", k, ready_o); else pass_cnt++;
         total_cnt++; if (v_o !== (k >= 1)) $display("FAIL wrap_v%0d: got %b expected %b", k, v_o, k >= 1); else pass_cnt++;
         if (k >= 1) begin
            total_cnt++; if (data_o !== 8'(8'h30 + k - 1)) $display("FAIL wrap_data%0d: got %h expected %h", k, data_o, 8'(8'h30 + k - 1)); else pass_cnt++;
         end
         v_i = 1'b1; data_i = 8'(8'h30 + k);
         yumi_i = (k >= 1);
         deq_v_i = (k >= 2); deq_cnt_i = (k >= 2) ? 2'd1 : 2'd0;
         tick();
      end
      idle();
   endtask

`ifdef BP_FE_QUEUE_BYPASS_EN
   task automatic test_bypass();
      do_reset();
      v_i = 1'b1; data_i = 8'h5A; yumi_i = 1'b1;
      #1;
      total_cnt++; if (v_o !== 1'b1 || data_o !== 8'h5A) $display("FAIL bypass_same_cycle: got v=%b %h expected v=1 5a", v_o, data_o); else pass_cnt++;
      tick(); idle();
      total_cnt++; if (v_o !== 1'b0 || count_o !== 4'd1) $display("FAIL bypass_consumed: got v=%b count=%0d expected v=0 count=1", v_o, count_o); else pass_cnt++;
      roll_v_i = 1'b1; tick(); idle();
      total_cnt++; if (v_o !== 1'b1 || data_o !== 8'h5A) $display("FAIL bypass_replay: got v=%b %h expected v=1 5a", v_o, data_o); else pass_cnt++;
   endtask
`else
   task automatic test_bypass();
      do_reset();
      v_i = 1'b1; data_i = 8'h5A;
      #1;
      total_cnt++; if (v_o !== 1'b0) $display("FAIL latency_same_cycle_v: got %b expected 0", v_o); else pass_cnt++;
      tick(); idle();
      total_cnt++; if (v_o !== 1'b1 || data_o !== 8'h5A) $display("FAIL latency_next_cycle: got v=%b %h expected v=1 5a", v_o, data_o); else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_fill();
      test_replay();
      test_multi_commit();
      test_flush();
      test_wrap();
      test_bypass();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
